// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master (fetch / memory-stage) arbiter onto one shared bus.
// Grants alternate under contention. A transaction is abandoned after
// TIMEOUT busy cycles without a data response.
module bus_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        ireq_valid,
    input  logic [63:0] ireq_addr,
    output logic        iresp_addr_ok,
    output logic        iresp_data_ok,
    output logic [31:0] iresp_data,

    input  logic        dreq_valid,
    input  logic [63:0] dreq_addr,
    input  logic [2:0]  dreq_size,
    input  logic [7:0]  dreq_strobe,
    input  logic [63:0] dreq_data,
    output logic        dresp_addr_ok,
    output logic        dresp_data_ok,
    output logic [63:0] dresp_data,

    output logic        breq_valid,
    output logic [63:0] breq_addr,
    output logic [2:0]  breq_size,
    output logic [7:0]  breq_strobe,
    output logic [63:0] breq_data,
    input  logic        bresp_addr_ok,
    input  logic        bresp_data_ok,
    input  logic [63:0] bresp_data,

    output logic        bus_timeout
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] IBUSY = 2'd1;
    localparam logic [1:0] DBUSY = 2'd2;

    // Counter value seen in the last busy cycle before the transaction is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic        last_d;      // 1 when the most recent grant went to the memory stage
    logic        bvalid_r;
    logic [7:0]  cnt;
    logic        timeout_r;

    logic [63:0] addr_r;
    logic [2:0]  size_r;
    logic [7:0]  strobe_r;
    logic [63:0] data_r;

    logic        grant_d;
    logic        grant_i;
    logic        at_limit;
    logic        i_busy;
    logic        d_busy;

    // Arbitration: D wins unless I also wants the bus and D had the last grant.
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state == IDLE) begin
            if (dreq_valid && (!ireq_valid || !last_d)) begin
                grant_d = 1'b1;
            end else if (ireq_valid) begin
                grant_i = 1'b1;
            end
        end
    end

    assign at_limit = (cnt == CNT_LAST);
    assign i_busy   = (state == IBUSY);
    assign d_busy   = (state == DBUSY);

    // Control state: FSM, fairness bit, address-phase valid, wait counter, timeout pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            bvalid_r  <= 1'b0;
            cnt       <= 8'd0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state    <= DBUSY;
                        last_d   <= 1'b1;
                        bvalid_r <= 1'b1;
                        cnt      <= 8'd0;
                    end else if (grant_i) begin
                        state    <= IBUSY;
                        last_d   <= 1'b0;
                        bvalid_r <= 1'b1;
                        cnt      <= 8'd0;
                    end
                end
                IBUSY, DBUSY: begin
                    if (bresp_data_ok) begin
                        // A response arriving in the limit cycle still completes normally.
                        state    <= IDLE;
                        bvalid_r <= 1'b0;
                    end else if (at_limit) begin
                        state     <= IDLE;
                        bvalid_r  <= 1'b0;
                        timeout_r <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (bresp_addr_ok) begin
                            bvalid_r <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    bvalid_r <= 1'b0;
                end
            endcase
        end
    end

    // Request payload captured at grant; the bus side only ever sees these registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r   <= 64'd0;
            size_r   <= 3'd0;
            strobe_r <= 8'd0;
            data_r   <= 64'd0;
        end else if (grant_d) begin
            addr_r   <= dreq_addr;
            size_r   <= dreq_size;
            strobe_r <= dreq_strobe;
            data_r   <= dreq_data;
        end else if (grant_i) begin
            addr_r   <= ireq_addr;
            size_r   <= 3'b010;
            strobe_r <= 8'd0;
            data_r   <= 64'd0;
        end
    end

    assign breq_valid  = bvalid_r;
    assign breq_addr   = addr_r;
    assign breq_size   = size_r;
    assign breq_strobe = strobe_r;
    assign breq_data   = data_r;
    assign bus_timeout = timeout_r;

    // Handshakes are routed only to the side that owns the current transaction.
    assign iresp_addr_ok = i_busy & bresp_addr_ok;
    assign iresp_data_ok = i_busy & bresp_data_ok;
    assign dresp_addr_ok = d_busy & bresp_addr_ok;
    assign dresp_data_ok = d_busy & bresp_data_ok;

    // Fetch returns the 32-bit half selected by the latched word address bit.
    assign iresp_data = i_busy ? (addr_r[2] ? bresp_data[63:32] : bresp_data[31:0]) : 32'd0;
    assign dresp_data = d_busy ? bresp_data : 64'd0;

endmodule
